bram_readback_checker: RTL and testbench

BRAM_READBACK_CHECKER -- requirements
Module: bram_readback_checker

---
 rtl/bram_readback_checker.sv | 177 +++++++++++++++++
 tb/tb_bram_readback_checker.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_readback_checker.sv
// -----------------------------------------------------------------------------
// bram_readback_checker
//
// Watches the read port of a BRAM and checks every word read back against a
// fixed address pattern: expected word = (addr + PAT_OFS) mod 2^DATA_W.
// The issued read enable and address are delayed RD_LAT cycles so that they
// line up with the returned data. A pass ends after DEPTH valid compares.
//
// Optional feature (compile-time macro):
//   BRAM_CHK_INJECT_EN - when defined, inj_err=1 on a valid data cycle inverts
//                        bit 0 of rd_data before the compare and the capture.
//                        When undefined, inj_err has no effect.
//
// Ports:
//   clk            - single clock
//   rst            - asynchronous active-low reset
//   start          - one-cycle pulse, begins (or restarts) a check pass
//   rd_en          - BRAM port-B read enable as issued to the memory
//   rd_addr        - BRAM port-B read address as issued
//   rd_data        - BRAM port-B read data (RD_LAT cycles after rd_en)
//   inj_err        - error-injection request (see macro above)
//   busy           - high while a pass is in progress
//   done           - one-cycle pulse when a pass completes
//   pass           - last completed pass had zero mismatches
//   err_cnt        - mismatch count, saturates at 16'hFFFF
//   first_err_addr - address of the first mismatch of the pass
//   first_err_data - data read at the first mismatch of the pass
//   chk_cnt        - words compared in the current pass
// -----------------------------------------------------------------------------
module bram_readback_checker #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int DEPTH   = 2048,
    parameter int RD_LAT  = 1,
    parameter int PAT_OFS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              inj_err,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [15:0]       chk_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Read-request delay line, aligned with rd_data at its last stage.
    logic [RD_LAT-1:0] v_pipe;
    logic [ADDR_W-1:0] a_pipe [RD_LAT];
    logic              v_d;
    logic [ADDR_W-1:0] a_d;

    logic              cmp_en;
    logic              cmp_last;
    logic              mismatch;
    logic [DATA_W-1:0] data_eff;
    logic [DATA_W-1:0] exp_data;

    assign v_d = v_pipe[RD_LAT-1];
    assign a_d = a_pipe[RD_LAT-1];

`ifdef BRAM_CHK_INJECT_EN
    assign data_eff = rd_data ^ DATA_W'(inj_err & v_d);
`else
    logic unused_inj;
    assign unused_inj = inj_err;
    assign data_eff   = rd_data;
`endif

    // A start in CHECK restarts the pass, so that cycle's data is discarded.
    assign cmp_en   = (state == CHECK) && v_d && !start;
    assign exp_data = DATA_W'(a_d) + DATA_W'(PAT_OFS);
    assign mismatch = cmp_en && (data_eff != exp_data);
    assign cmp_last = cmp_en && (chk_cnt == 16'(DEPTH - 1));

    assign busy = (state == CHECK);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   if (start) state_nxt = CHECK;
                     else if (cmp_last) state_nxt = DONE;
            DONE:    state_nxt = start ? CHECK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Valid bits only advance while checking; they are held at zero elsewhere,
    // which also flushes them on every (re)entry to CHECK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_pipe <= '0;
        end else if (state == CHECK && !start) begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                v_pipe[i] <= v_pipe[i-1];
            end
            v_pipe[0] <= rd_en;
        end else begin
            v_pipe <= '0;
        end
    end

    // NOTE: the address delay line is qualified by v_pipe, so it carries no
    // reset; that keeps it a plain shift register without reset routing.
    always_ff @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            a_pipe[i] <= a_pipe[i-1];
        end
        a_pipe[0] <= rd_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass           <= 1'b0;
            err_cnt        <= '0;
            chk_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            if (state == DONE) begin
                pass <= (err_cnt == 16'd0);
            end

            if (start) begin
                err_cnt        <= '0;
                chk_cnt        <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
                if (state == IDLE) begin
                    pass <= 1'b0;
                end
            end else if (cmp_en) begin
                chk_cnt <= chk_cnt + 16'd1;
                if (mismatch) begin
                    // err_cnt only returns to zero via start/reset, so zero
                    // here identifies the first mismatch of the pass.
                    if (err_cnt == 16'd0) begin
                        first_err_addr <= a_d;
                        first_err_data <= data_eff;
                    end
                    if (err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_readback_checker.sv
// -----------------------------------------------------------------------------
// tb_bram_readback_checker
//
// Drives read traffic into bram_readback_checker through a behavioural BRAM
// (pattern memory with optional corrupted words) and checks the pass results
// against a reference model that scores the first DEPTH issued reads.
// Define BRAM_CHK_INJECT_EN for both bench and RTL to exercise injection.
// -----------------------------------------------------------------------------
module tb_bram_readback_checker;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 20;
    localparam int DEPTH   = 2048;
    localparam int RD_LAT  = 2;
    localparam int PAT_OFS = 1;

`ifdef BRAM_CHK_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              inj_err;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;
    logic [15:0]       chk_cnt;

    logic              inj_req;

    int n_chk = 0;
    int n_ok  = 0;

    bram_readback_checker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .PAT_OFS(PAT_OFS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .inj_err       (inj_err),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .chk_cnt       (chk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural BRAM ----------------
    int          bad_addr_q [$];
    logic [15:0] bad_val_q  [$];

    function automatic logic [15:0] mem_val(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < bad_addr_q.size(); i++) begin
            if (bad_addr_q[i] == int'(a)) return bad_val_q[i];
        end
        return 16'((int'(a) + PAT_OFS) % 65536);
    endfunction

    logic [15:0]       dq [RD_LAT];
    logic [RD_LAT-1:0] iq;

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            dq[i] <= dq[i-1];
            iq[i] <= iq[i-1];
        end
        dq[0] <= rd_en ? mem_val(rd_addr) : 16'($urandom);
        iq[0] <= rd_en & inj_req;
    end

    assign rd_data = dq[RD_LAT-1];
    assign inj_err = iq[RD_LAT-1];

    // ---------------- reference model ----------------
    int          m_cnt;
    logic [15:0] m_err;
    logic [19:0] m_first_addr;
    logic [15:0] m_first_data;

    task automatic model_clear();
        m_cnt        = 0;
        m_err        = 16'd0;
        m_first_addr = 20'd0;
        m_first_data = 16'd0;
    endtask

    task automatic model_read(input logic [19:0] a, input logic [15:0] d);
        logic [15:0] expd;
        expd = 16'((int'(a) + PAT_OFS) % 65536);
        if (m_cnt < DEPTH) begin
            m_cnt++;
            if (d != expd) begin
                if (m_err == 16'd0) begin
                    m_first_addr = a;
                    m_first_data = d;
                end
                if (m_err != 16'hFFFF) m_err++;
            end
        end
    endtask

    // ---------------- stimulus tasks ----------------
    // mode 0: sequential, back to back; 1: sequential, 1/0 toggling rd_en;
    // 2: random addresses, random gaps, random corrupted words.
    task automatic issue_reads(input int n, input int mode, input int n_inj);
        int          bad;
        int          injected;
        int          inj_base;
        logic [19:0] a;
        logic        inj;
        bad      = 0;
        injected = 0;
        inj_base = $urandom_range(0, n / 2);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (mode == 1) ? 1 : (mode == 2) ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                if (!busy || done) bad++;
                rd_en   = 1'b0;
                inj_req = 1'b0;
                rd_addr = 20'($urandom);
            end
            @(negedge clk);
            if (!busy || done) bad++;
            a = (mode == 2) ? 20'($urandom) : 20'(i);
            if (mode == 2 && $urandom_range(0, 49) == 0) begin
                bad_addr_q.push_front(int'(a));
                bad_val_q.push_front(16'((int'(a) + PAT_OFS) % 65536) ^ 16'($urandom_range(1, 65535)));
            end
            inj = (injected < n_inj) && (i >= inj_base) && ((i - inj_base) % 7 == 0);
            if (inj) injected++;
            rd_en   = 1'b1;
            rd_addr = a;
            inj_req = inj;
            model_read(a, mem_val(a) ^ {15'd0, inj & INJ_ON});
        end
        n_chk++;
        if (bad != 0) $display("FAIL busy_during_pass: %0d cycles with busy=0 or done=1, required 0", bad);
        else n_ok++;
    endtask

    task automatic start_pass();
        @(negedge clk);
        rd_en   = 1'b0;
        inj_req = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear();
        n_chk++;
        if ({busy, done, err_cnt, chk_cnt} !== {1'b1, 1'b0, 16'd0, 16'd0})
            $display("FAIL start_clear: busy=%0b done=%0b err_cnt=%0d chk_cnt=%0d, required 1 0 0 0",
                     busy, done, err_cnt, chk_cnt);
        else n_ok++;
    endtask

    // Called right after the last read was driven; done must appear exactly
    // RD_LAT+1 cycles later, then results are compared in IDLE.
    task automatic finish_pass(input string tag);
        int lat;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            rd_en   = 1'b0;
            inj_req = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        n_chk++;
        if (lat != RD_LAT + 1) $display("FAIL %s done_latency: got %0d cycles, required %0d", tag, lat, RD_LAT + 1);
        else n_ok++;
        @(negedge clk);
        n_chk++;
        if ({busy, done} !== 2'b00) $display("FAIL %s after_done: busy=%0b done=%0b, required 0 0", tag, busy, done);
        else n_ok++;
        n_chk++;
        if (pass !== (m_err == 16'd0)) $display("FAIL %s pass: got %0b required %0b", tag, pass, m_err == 16'd0);
        else n_ok++;
        n_chk++;
        if (err_cnt !== m_err) $display("FAIL %s err_cnt: got %0d required %0d", tag, err_cnt, m_err);
        else n_ok++;
        n_chk++;
        if (chk_cnt !== 16'(m_cnt)) $display("FAIL %s chk_cnt: got %0d required %0d", tag, chk_cnt, m_cnt);
        else n_ok++;
        n_chk++;
        if ({first_err_addr, first_err_data} !== {m_first_addr, m_first_data})
            $display("FAIL %s first_err: got %0h/%0h required %0h/%0h", tag,
                     first_err_addr, first_err_data, m_first_addr, m_first_data);
        else n_ok++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_chk++;
        if ({busy, done, pass, err_cnt, chk_cnt, first_err_addr, first_err_data} !== '0)
            $display("FAIL reset_state: busy=%0b done=%0b pass=%0b err=%0d chk=%0d fa=%0h fd=%0h, required all 0",
                     busy, done, pass, err_cnt, chk_cnt, first_err_addr, first_err_data);
        else n_ok++;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        rd_en = 1'b1;
        repeat (4) @(negedge clk);
        rd_en = 1'b0;
        n_chk++;
        if ({busy, done, chk_cnt} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL reset_release_idle: busy=%0b done=%0b chk=%0d, required 0 0 0", busy, done, chk_cnt);
        else n_ok++;
    endtask

    task automatic test_clean_pass();
        start_pass();
        issue_reads(DEPTH, 0, 0);
        finish_pass("clean");
    endtask

    task automatic test_single_corruption();
        bad_addr_q.push_back(100);
        bad_val_q.push_back(16'h0000);
        start_pass();
        issue_reads(DEPTH, 0, 0);
        finish_pass("corrupt100");
        n_chk++;
        if ({pass, err_cnt, first_err_addr, first_err_data} !== {1'b0, 16'd1, 20'd100, 16'h0000})
            $display("FAIL corrupt100_const: pass=%0b err=%0d fa=%0d fd=%0h, required 0 1 100 0",
                     pass, err_cnt, first_err_addr, first_err_data);
        else n_ok++;
        bad_addr_q.delete();
        bad_val_q.delete();
    endtask

    task automatic test_idle_ignore();
        logic [15:0] e0;
        logic [15:0] c0;
        e0 = err_cnt;
        c0 = chk_cnt;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rd_en   = 1'b1;
            rd_addr = 20'($urandom);
        end
        @(negedge clk);
        rd_en = 1'b0;
        repeat (RD_LAT + 2) @(negedge clk);
        n_chk++;
        if ({busy, err_cnt, chk_cnt} !== {1'b0, e0, c0})
            $display("FAIL idle_ignore: busy=%0b err=%0d chk=%0d, required 0 %0d %0d", busy, err_cnt, chk_cnt, e0, c0);
        else n_ok++;
    endtask

    task automatic test_gapped();
        start_pass();
        issue_reads(DEPTH, 1, 0);
        finish_pass("gapped");
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            start_pass();
            issue_reads(DEPTH, 2, 0);
            finish_pass("random");
            bad_addr_q.delete();
            bad_val_q.delete();
        end
    endtask

    task automatic test_reset_mid_pass();
        int seen;
        start_pass();
        issue_reads(500, 0, 0);
        @(negedge clk);
        rd_en = 1'b0;
        repeat (RD_LAT) @(negedge clk);
        n_chk++;
        if ({busy, chk_cnt} !== {1'b1, 16'd500}) $display("FAIL pre_abort: busy=%0b chk=%0d, required 1 500", busy, chk_cnt);
        else n_ok++;
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, pass, err_cnt, chk_cnt, first_err_addr, first_err_data} !== '0)
            $display("FAIL abort_reset: busy=%0b done=%0b pass=%0b err=%0d chk=%0d, required all 0",
                     busy, done, pass, err_cnt, chk_cnt);
        else n_ok++;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_chk++;
        if (seen != 0) $display("FAIL abort_no_done: %0d cycles with done/busy after reset, required 0", seen);
        else n_ok++;
        start_pass();
        issue_reads(DEPTH, 0, 0);
        finish_pass("after_abort");
    endtask

    task automatic test_restart();
        bad_addr_q = '{10, 20, 30};
        bad_val_q  = '{16'hBEEF, 16'h1234, 16'h0000};
        start_pass();
        issue_reads(1000, 0, 0);
        @(negedge clk);
        rd_en = 1'b0;
        repeat (RD_LAT) @(negedge clk);
        n_chk++;
        if ({err_cnt, chk_cnt} !== {m_err, 16'(m_cnt)} || m_err != 16'd3)
            $display("FAIL pre_restart: err=%0d chk=%0d, required %0d %0d (3 errors)", err_cnt, chk_cnt, m_err, m_cnt);
        else n_ok++;
        start_pass();
        issue_reads(DEPTH, 0, 0);
        finish_pass("restart");
        bad_addr_q.delete();
        bad_val_q.delete();
    endtask

    task automatic test_start_in_done();
        int hit;
        start_pass();
        issue_reads(DEPTH, 0, 0);
        hit = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            rd_en = 1'b0;
            if (done) begin
                start = 1'b1;
                hit   = 1;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        model_clear();
        n_chk++;
        if (hit != 1 || {busy, done, chk_cnt, err_cnt} !== {1'b1, 1'b0, 16'd0, 16'd0})
            $display("FAIL start_in_done: seen_done=%0d busy=%0b done=%0b chk=%0d err=%0d, required 1 1 0 0 0",
                     hit, busy, done, chk_cnt, err_cnt);
        else n_ok++;
        issue_reads(DEPTH, 0, 0);
        finish_pass("from_done");
    endtask

    task automatic test_inject();
        start_pass();
        issue_reads(DEPTH, 0, 5);
        finish_pass("inject");
        n_chk++;
        if (err_cnt !== (INJ_ON ? 16'd5 : 16'd0))
            $display("FAIL inject_count: got %0d required %0d", err_cnt, INJ_ON ? 5 : 0);
        else n_ok++;
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        inj_req = 1'b0;
        model_clear();
        test_reset();
        test_clean_pass();
        test_idle_ignore();
        test_single_corruption();
        test_gapped();
        test_random();
        test_reset_mid_pass();
        test_restart();
        test_start_in_done();
        test_inject();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
